lfsr_prng_sampler: RTL and testbench

Pseudo-random source feeding the seven-segment display controller's 4-bit `binary_data` input. It holds a parameterised Galois LFSR that advances either free-running at a divided tick rate or one step per button press. After each advance it presents the low nibble of the new state as a registered 4-bit sample, with a one-cycle valid strobe. Seed loading with all-zero protection is included so the generator can never lock up.

---
 rtl/lfsr_prng_sampler_pkg.sv | 17 +
 rtl/lfsr_prng_sampler_if.sv | 23 ++
 rtl/lfsr_prng_sampler_btn_sync_edge.sv | 25 ++
 rtl/lfsr_prng_sampler.sv | 89 ++++++++
 tb/tb_lfsr_prng_sampler.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_prng_sampler_pkg.sv
// Shared constants, FSM state type and LFSR step function for the PRNG sampler.
package prng_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam logic [15:0] DEF_TAPS  = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;

    typedef logic [0:0] state_t;
    localparam state_t S_STOP = 1'b0;
    localparam state_t S_RUN  = 1'b1;

    // Galois step on a zero-extended state; callers truncate back to their width.
    function automatic logic [63:0] lfsr_next(input logic [63:0] state, input logic [63:0] taps);
        return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/lfsr_prng_sampler_if.sv
// Control/sample bundle between the PRNG sampler and its driver (panel logic / display).
interface lfsr_prng_sampler_if import prng_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             run;
    logic             step_btn;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic [3:0]       binary_data;
    logic             sample_valid;
    logic [WIDTH-1:0] lfsr_state;
    logic             seed_rejected;

    modport master (
        output run, step_btn, seed_load, seed_in,
        input  binary_data, sample_valid, lfsr_state, seed_rejected
    );

    modport slave (
        input  run, step_btn, seed_load, seed_in,
        output binary_data, sample_valid, lfsr_state, seed_rejected
    );
endinterface

// File: rtl/lfsr_prng_sampler_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button followed by a rising-edge pulse.
module btn_sync_edge (
    input  logic clock_10Mhz,
    input  logic reset_n,
    input  logic btn,
    output logic btn_pulse
);
    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clock_10Mhz) begin
        if (!reset_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= btn;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign btn_pulse = sync_2 & ~sync_prev;
endmodule

// File: rtl/lfsr_prng_sampler.sv
// Galois-LFSR random nibble source: free-run at a divided tick or single-step per button press.
module lfsr_prng_sampler import prng_pkg::*; #(
    parameter int unsigned      WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEF_SEED),
    parameter int unsigned      TICK_DIV = 10_000_000
) (
    input  logic               clock_10Mhz,
    input  logic               reset_n,
    lfsr_prng_sampler_if.slave bus
);
    localparam int unsigned   CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    state_t           state;
    logic [CW-1:0]    tick;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] seed_val;
    logic [3:0]       data;
    logic             valid;
    logic             rejected;
    logic             step_pulse;
    logic             tick_done;
    logic             seed_zero;
    logic             advance;

    btn_sync_edge u_step (
        .clock_10Mhz (clock_10Mhz),
        .reset_n     (reset_n),
        .btn         (bus.step_btn),
        .btn_pulse   (step_pulse)
    );

    always_comb begin
        lfsr_nxt  = WIDTH'(lfsr_next(64'(lfsr), 64'(TAPS)));
        seed_zero = (bus.seed_in == '0);
        seed_val  = seed_zero ? SEED : bus.seed_in;
        tick_done = (tick == TICK_LAST);
        // A step edge arriving while running is simply never acted on.
        advance   = (state == S_RUN) ? (bus.run && tick_done) : step_pulse;
    end

    always_ff @(posedge clock_10Mhz) begin
        if (!reset_n) begin
            state    <= S_STOP;
            tick     <= '0;
            lfsr     <= SEED;
            data     <= SEED[3:0];
            valid    <= 1'b0;
            rejected <= 1'b0;
        end else begin
            valid    <= 1'b0;
            rejected <= 1'b0;

            if (state == S_STOP) begin
                tick <= '0;
                if (bus.run) state <= S_RUN;
            end else if (!bus.run) begin
                state <= S_STOP;
                tick  <= '0;
            end else if (tick_done) begin
                tick <= '0;
            end else begin
                tick <= tick + 1'b1;
            end

            // Seed load wins over a coincident advance, which is dropped.
            if (bus.seed_load) begin
                tick     <= '0;
                lfsr     <= seed_val;
                data     <= seed_val[3:0];
                valid    <= 1'b1;
                rejected <= seed_zero;
            end else if (advance) begin
                lfsr  <= lfsr_nxt;
                data  <= lfsr_nxt[3:0];
                valid <= 1'b1;
            end
        end
    end

    assign bus.binary_data   = data;
    assign bus.sample_valid  = valid;
    assign bus.lfsr_state    = lfsr;
    assign bus.seed_rejected = rejected;

    a_nonzero_state: assert property (@(posedge clock_10Mhz) reset_n |-> (lfsr != '0));
endmodule

// File: tb/tb_lfsr_prng_sampler.sv
// Randomised and directed check of lfsr_prng_sampler against an edge-counting behavioural model.
module tb_lfsr_prng_sampler;
    localparam int unsigned TDIV   = 4;
    localparam logic [15:0] TAPS_C = 16'hB400;
    localparam logic [15:0] SEED_C = 16'hACE1;

    logic clock_10Mhz = 1'b0;
    logic reset_n     = 1'b0;
    always #5 clock_10Mhz = ~clock_10Mhz;

    lfsr_prng_sampler_if #(.WIDTH(16)) prng ();

    lfsr_prng_sampler #(
        .WIDTH    (16),
        .TAPS     (TAPS_C),
        .SEED     (SEED_C),
        .TICK_DIV (TDIV)
    ) dut (
        .clock_10Mhz (clock_10Mhz),
        .reset_n     (reset_n),
        .bus         (prng)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: state value, mode seen last edge, last three sampled button levels, run edges since restart.
    logic [15:0] m_state;
    bit          m_run;
    bit [2:0]    m_hist;
    int unsigned m_edges;
    bit          m_sv;
    bit          m_rej;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] half;
        half = s / 16'd2;
        return (s % 16'd2 == 16'd1) ? (half ^ TAPS_C) : half;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("lfsr_state", 32'(prng.lfsr_state), 32'(m_state));
        check("binary_data", 32'(prng.binary_data), 32'(m_state[3:0]));
        check("sample_valid", 32'(prng.sample_valid), 32'(m_sv));
        check("seed_rejected", 32'(prng.seed_rejected), 32'(m_rej));
    endtask

    task automatic model_reset();
        m_state = SEED_C;
        m_run   = 1'b0;
        m_hist  = '0;
        m_edges = 0;
        m_sv    = 1'b0;
        m_rej   = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit b, input bit l, input logic [15:0] sd);
        bit pulse;
        pulse = m_hist[1] && !m_hist[2];
        m_sv  = 1'b0;
        m_rej = 1'b0;
        if (l) begin
            m_state = (sd == 16'd0) ? SEED_C : sd;
            m_sv    = 1'b1;
            m_rej   = (sd == 16'd0);
            m_edges = 0;
        end else if (m_run && r) begin
            m_edges++;
            if (m_edges == TDIV) begin
                m_state = model_step(m_state);
                m_sv    = 1'b1;
                m_edges = 0;
            end
        end else if (!m_run && pulse) begin
            m_state = model_step(m_state);
            m_sv    = 1'b1;
        end
        if (m_run != r) m_edges = 0;
        m_run  = r;
        m_hist = {m_hist[1:0], b};
    endtask

    task automatic cycle(input bit r, input bit b, input bit l, input logic [15:0] sd);
        prng.run       = r;
        prng.step_btn  = b;
        prng.seed_load = l;
        prng.seed_in   = sd;
        @(posedge clock_10Mhz);
        model_edge(r, b, l, sd);
        @(negedge clock_10Mhz);
        check_outputs();
    endtask

    task automatic do_reset(input int unsigned n, input bit r);
        reset_n        = 1'b0;
        prng.run       = r;
        prng.step_btn  = 1'b0;
        prng.seed_load = 1'b1;
        prng.seed_in   = 16'h0000;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock_10Mhz);
            model_reset();
            @(negedge clock_10Mhz);
            check_outputs();
        end
        reset_n        = 1'b1;
        prng.seed_load = 1'b0;
    endtask

    initial begin
        logic [15:0] step_exp [3];
        int unsigned cnt;
        int          pos;
        int          adv_pos [$];
        bit          r, b, l;
        logic [15:0] sd;

        step_exp[0] = 16'hE270;
        step_exp[1] = 16'h7138;
        step_exp[2] = 16'h389C;

        prng.run       = 1'b0;
        prng.step_btn  = 1'b0;
        prng.seed_load = 1'b0;
        prng.seed_in   = '0;
        model_reset();
        @(negedge clock_10Mhz);

        do_reset(3, 1'b0);
        check("reset_state_const", 32'(prng.lfsr_state), 32'h0000ACE1);
        check("reset_data_const", 32'(prng.binary_data), 32'h1);

        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            pos = -1;
            for (int c = 0; c < 6; c++) begin
                cycle(1'b0, (c < 2), 1'b0, 16'h0);
                if (prng.sample_valid) begin
                    cnt++;
                    pos = c;
                end
            end
            check("step_state_const", 32'(prng.lfsr_state), 32'(step_exp[i]));
            check("step_data_const", 32'(prng.binary_data), 32'(step_exp[i][3:0]));
            check("step_pulse_count", cnt, 1);
            check("step_latency", 32'(pos), 32'd2);
        end

        cnt = 0;
        for (int c = 0; c < 55; c++) begin
            cycle(1'b0, (c < 50), 1'b0, 16'h0);
            if (prng.sample_valid) cnt++;
        end
        check("held_btn_count", cnt, 1);

        for (int c = 0; c <= 12; c++) begin
            cycle(1'b1, (c % 3 == 1), 1'b0, 16'h0);
            if (prng.sample_valid) adv_pos.push_back(c);
        end
        check("freerun_count", 32'(adv_pos.size()), 32'd3);
        for (int k = 0; k < adv_pos.size() && k < 3; k++)
            check("freerun_edge", 32'(adv_pos[k]), 32'((k + 1) * 4));

        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0001);
        check("seed1_state", 32'(prng.lfsr_state), 32'h0001);
        check("seed1_valid", 32'(prng.sample_valid), 32'h1);
        for (int c = 0; c < 6; c++) cycle(1'b0, (c < 2), 1'b0, 16'h0);
        check("seed1_step", 32'(prng.lfsr_state), 32'hB400);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        check("seed0_state", 32'(prng.lfsr_state), 32'hACE1);
        check("seed0_rejected", 32'(prng.seed_rejected), 32'h1);

        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b1, 16'h1234);
        check("seed_vs_tick_state", 32'(prng.lfsr_state), 32'h1234);
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
        check("seed_vs_tick_hold", 32'(prng.lfsr_state), 32'h1234);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        check("seed_vs_tick_next", 32'(prng.lfsr_state), 32'h091A);

        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        do_reset(1, 1'b1);
        check("midreset_state", 32'(prng.lfsr_state), 32'hACE1);
        pos = -1;
        for (int c = 0; c <= 4; c++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'h0);
            if (prng.sample_valid && pos < 0) pos = c;
        end
        check("midreset_first_adv", 32'(pos), 32'd4);
        check("midreset_adv_state", 32'(prng.lfsr_state), 32'hE270);

        r = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom % 40 == 0) r = ~r;
            if ($urandom % 6 == 0) b = ~b;
            l  = ($urandom % 25 == 0);
            sd = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom);
            if ($urandom % 200 == 0) do_reset(1, r);
            else cycle(r, b, l, sd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
